// File: rtl/lcd_pkg.sv
// Shared constants, state types and helpers for the HD44780 4-bit stream controller.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_2L = 8'h28;
  localparam logic [7:0] LCD_CMD_FUNC_1L = 8'h20;
  localparam logic [7:0] LCD_CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LCD_LINE0 = 7'h00;
  localparam logic [6:0] LCD_LINE1 = 7'h40;

  localparam int unsigned LCD_WAIT_W = 3;

  typedef enum logic [3:0] {
    ST_DELAY, ST_N3A, ST_N3B, ST_N3C, ST_N2,
    ST_FUNC, ST_DISP, ST_CLEAR, ST_ENTRY,
    ST_IDLE, ST_XFER, ST_WRAP
  } lcd_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_HI, TX_GAP, TX_LO, TX_WAIT
  } lcd_tx_phase_e;

  // Clear and home need extra settling ticks after the low nibble.
  function automatic logic [LCD_WAIT_W-1:0] lcd_cmd_wait(input logic [7:0] b, input logic is_char);
    return (!is_char && (b == LCD_CMD_CLEAR || b == LCD_CMD_HOME)) ? LCD_WAIT_W'(2) : '0;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Serialises one byte (or a single high nibble) onto the 4-bit LCD bus, one step per tick,
// followed by an optional number of idle wait ticks.
module lcd_nibble_tx
  import lcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_tick,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_rs,
  input  logic                  i_single,
  input  logic [LCD_WAIT_W-1:0] i_wait,
  output logic                  o_en,
  output logic                  o_rs,
  output logic [3:0]            o_data,
  output logic                  o_done_c
);

  lcd_tx_phase_e         r_phase;
  logic [3:0]            r_lo;
  logic                  r_single;
  logic [LCD_WAIT_W-1:0] r_wait;
  logic                  r_en;
  logic                  r_rs;
  logic [3:0]            r_data;

  // Final step of the current job happens on this tick.
  assign o_done_c = i_tick &&
                    (((r_phase == TX_HI) && r_single && (r_wait == '0)) ||
                     ((r_phase == TX_LO) && (r_wait == '0)) ||
                     ((r_phase == TX_WAIT) && (r_wait == LCD_WAIT_W'(1))));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase  <= TX_IDLE;
      r_lo     <= '0;
      r_single <= 1'b0;
      r_wait   <= '0;
      r_en     <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= '0;
    end else if (i_tick) begin
      unique case (r_phase)
        TX_IDLE: if (i_start) begin
          r_data   <= i_byte[7:4];
          r_lo     <= i_byte[3:0];
          r_rs     <= i_rs;
          r_single <= i_single;
          r_wait   <= i_wait;
          r_en     <= 1'b1;
          r_phase  <= TX_HI;
        end
        TX_HI: begin
          r_en <= 1'b0;
          if (!r_single)          r_phase <= TX_GAP;
          else if (r_wait == '0)  r_phase <= TX_IDLE;
          else                    r_phase <= TX_WAIT;
        end
        TX_GAP: begin
          r_data  <= r_lo;
          r_en    <= 1'b1;
          r_phase <= TX_LO;
        end
        TX_LO: begin
          r_en    <= 1'b0;
          r_phase <= (r_wait == '0) ? TX_IDLE : TX_WAIT;
        end
        TX_WAIT: begin
          r_wait <= r_wait - LCD_WAIT_W'(1);
          if (r_wait == LCD_WAIT_W'(1)) r_phase <= TX_IDLE;
        end
        default: r_phase <= TX_IDLE;
      endcase
    end
  end

  assign o_en   = r_en;
  assign o_rs   = r_rs;
  assign o_data = r_data;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit controller: ms prescaler, power-on init, valid/ready byte stream, cursor tracking.
// Optional LCD_AUTOWRAP_EN inserts a set-DDRAM command to the next line when a line fills.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned COLS          = 16,
  parameter int unsigned LINES         = 2,
  parameter int unsigned INIT_DELAY_MS = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic       init_done,
  output logic       en,
  output logic       rs,
  output logic [3:0] data,
  output logic [5:0] cur_col,
  output logic       cur_line
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DLY_W   = (INIT_DELAY_MS > 1) ? $clog2(INIT_DELAY_MS + 1) : 1;
`ifdef LCD_AUTOWRAP_EN
  localparam bit AUTOWRAP = 1'b1;
`else
  localparam bit AUTOWRAP = 1'b0;
`endif

  logic [PRESC_W-1:0]    r_presc;
  logic [DLY_W-1:0]      r_dly;
  lcd_state_e            r_state;
  logic                  r_ready;
  logic                  r_init_done;
  logic [5:0]            r_col;
  logic                  r_line;
  logic [7:0]            r_byte;
  logic                  r_rs;

  logic                  w_tick;
  logic                  w_tx_start;
  logic [7:0]            w_tx_byte;
  logic                  w_tx_rs;
  logic                  w_tx_single;
  logic [LCD_WAIT_W-1:0] w_tx_wait;
  logic                  w_tx_done_c;
  logic [5:0]            w_col_nxt;
  logic                  w_line_nxt;
  logic                  w_next_line;
  logic [6:0]            w_next_base;
  logic                  w_wrap;

  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  assign w_next_line = (LINES == 1) ? 1'b0 : ~r_line;
  assign w_next_base = w_next_line ? LCD_LINE1 : LCD_LINE0;

  // Job presented to the serialiser for the current sequencer state.
  always_comb begin
    w_tx_start  = 1'b1;
    w_tx_byte   = 8'h30;
    w_tx_rs     = 1'b0;
    w_tx_single = 1'b1;
    w_tx_wait   = '0;
    unique case (r_state)
      ST_N3A, ST_N3B: w_tx_wait = LCD_WAIT_W'(5);
      ST_N3C:         w_tx_wait = LCD_WAIT_W'(1);
      ST_N2:          w_tx_byte = 8'h20;
      ST_FUNC: begin
        w_tx_single = 1'b0;
        w_tx_byte   = (LINES == 1) ? LCD_CMD_FUNC_1L : LCD_CMD_FUNC_2L;
      end
      ST_DISP: begin
        w_tx_single = 1'b0;
        w_tx_byte   = LCD_CMD_DISP_ON;
      end
      ST_CLEAR: begin
        w_tx_single = 1'b0;
        w_tx_byte   = LCD_CMD_CLEAR;
        w_tx_wait   = lcd_cmd_wait(LCD_CMD_CLEAR, 1'b0);
      end
      ST_ENTRY: begin
        w_tx_single = 1'b0;
        w_tx_byte   = LCD_CMD_ENTRY;
      end
      ST_XFER: begin
        w_tx_single = 1'b0;
        w_tx_byte   = r_byte;
        w_tx_rs     = r_rs;
        w_tx_wait   = lcd_cmd_wait(r_byte, r_rs);
      end
      ST_WRAP: begin
        w_tx_single = 1'b0;
        w_tx_byte   = LCD_CMD_DDRAM | {1'b0, w_next_base};
      end
      default: w_tx_start = 1'b0;
    endcase
  end

  // Cursor effect of the byte currently being sent.
  always_comb begin
    w_col_nxt  = r_col;
    w_line_nxt = r_line;
    if (w_tx_rs) begin
      w_col_nxt = (r_col == 6'd63) ? r_col : r_col + 6'd1;
    end else if (w_tx_byte == LCD_CMD_CLEAR || w_tx_byte == LCD_CMD_HOME) begin
      w_col_nxt  = '0;
      w_line_nxt = 1'b0;
    end else if (w_tx_byte[7]) begin
      w_col_nxt  = w_tx_byte[5:0];
      w_line_nxt = (LINES == 1) ? 1'b0 : w_tx_byte[6];
    end
  end

  assign w_wrap = AUTOWRAP && r_rs && (w_col_nxt == 6'(COLS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_DELAY;
      r_dly       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_col       <= '0;
      r_line      <= 1'b0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
    end else begin
      unique case (r_state)
        ST_DELAY: if (w_tick) begin
          if (r_dly == DLY_W'(INIT_DELAY_MS - 1)) r_state <= ST_N3A;
          else                                    r_dly   <= r_dly + DLY_W'(1);
        end
        ST_N3A:   if (w_tx_done_c) r_state <= ST_N3B;
        ST_N3B:   if (w_tx_done_c) r_state <= ST_N3C;
        ST_N3C:   if (w_tx_done_c) r_state <= ST_N2;
        ST_N2:    if (w_tx_done_c) r_state <= ST_FUNC;
        ST_FUNC:  if (w_tx_done_c) r_state <= ST_DISP;
        ST_DISP:  if (w_tx_done_c) r_state <= ST_CLEAR;
        ST_CLEAR: if (w_tx_done_c) r_state <= ST_ENTRY;
        ST_ENTRY: if (w_tx_done_c) begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
        ST_IDLE: if (in_valid && r_ready) begin
          r_byte  <= in_data;
          r_rs    <= in_rs;
          r_ready <= 1'b0;
          r_state <= ST_XFER;
        end
        ST_XFER, ST_WRAP: if (w_tx_done_c) begin
          r_col  <= w_col_nxt;
          r_line <= w_line_nxt;
          if ((r_state == ST_XFER) && w_wrap) begin
            r_state <= ST_WRAP;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_DELAY;
      endcase
    end
  end

  lcd_nibble_tx u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_tick   (w_tick),
    .i_start  (w_tx_start),
    .i_byte   (w_tx_byte),
    .i_rs     (w_tx_rs),
    .i_single (w_tx_single),
    .i_wait   (w_tx_wait),
    .o_en     (en),
    .o_rs     (rs),
    .o_data   (data),
    .o_done_c (w_tx_done_c)
  );

  assign in_ready  = r_ready;
  assign init_done = r_init_done;
  assign cur_col   = r_col;
  assign cur_line  = r_line;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: init timing, byte stream, cursor tracking, reset, wrap (LCD_AUTOWRAP_EN).
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_ready, init_done, en, rs, cur_line;
  logic [3:0] data;
  logic [5:0] cur_col;

  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1  = 8'h00;
  logic       in_rs1    = 1'b0;
  logic       in_ready1, init_done1, en1, rs1, cur_line1;
  logic [3:0] data1;
  logic [5:0] cur_col1;

  int cyc = 0;
  int last_rise = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_ctrl #(.TICK_DIV(4), .COLS(16), .LINES(2), .INIT_DELAY_MS(40)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rs(in_rs), .init_done(init_done), .en(en), .rs(rs),
    .data(data), .cur_col(cur_col), .cur_line(cur_line)
  );

  lcd_ctrl #(.TICK_DIV(1), .COLS(16), .LINES(1), .INIT_DELAY_MS(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_rs(in_rs1), .init_done(init_done1), .en(en1), .rs(rs1),
    .data(data1), .cur_col(cur_col1), .cur_line(cur_line1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic en_of(input int sel);
    return (sel != 0) ? en1 : en;
  endfunction
  function automatic logic rs_of(input int sel);
    return (sel != 0) ? rs1 : rs;
  endfunction
  function automatic logic [3:0] data_of(input int sel);
    return (sel != 0) ? data1 : data;
  endfunction

  // Waits for the next E pulse and checks its rs/data, width, stability and spacing.
  task automatic expect_nib(input string tag, input int sel, input logic exp_rs,
                            input logic [3:0] exp_d, input int exp_gap, input int exp_w);
    int t = 0;
    int w = 0;
    int rise;
    logic stable = 1'b1;
    logic s_rs;
    logic [3:0] s_d;
    while (en_of(sel) !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    check({tag, "_seen"}, 32'(t < 3000), 1);
    rise = cyc;
    s_rs = rs_of(sel);
    s_d  = data_of(sel);
    while (en_of(sel) === 1'b1 && w < 50) begin
      if (rs_of(sel) !== s_rs || data_of(sel) !== s_d) stable = 1'b0;
      @(negedge clk);
      w++;
    end
    check({tag, "_rs"}, 32'(s_rs), 32'(exp_rs));
    check({tag, "_data"}, 32'(s_d), 32'(exp_d));
    check({tag, "_width"}, w, exp_w);
    check({tag, "_stable"}, 32'(stable), 1);
    if (exp_gap >= 0) check({tag, "_gap"}, rise - last_rise, exp_gap);
    last_rise = rise;
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    int t = 0;
    while (in_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    check("send_ready", 32'(t < 3000), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_rs    = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic xfer_char(input logic [7:0] d);
    send(d, 1'b1);
    expect_nib("chr_hi", 0, 1'b1, d[7:4], -1, 4);
    expect_nib("chr_lo", 0, 1'b1, d[3:0], 8, 4);
  endtask

  initial begin
    int n;
    int k;
    int c0;
    logic [7:0] ch;
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_rs = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(en), 0);
    check("rst_rs", 32'(rs), 0);
    check("rst_data", 32'(data), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_init", 32'(init_done), 0);
    check("rst_col", 32'(cur_col), 0);
    check("rst_line", 32'(cur_line), 0);
    check("rst1_en", 32'(en1), 0);
    check("rst1_ready", 32'(in_ready1), 0);
    check("rst1_pos", 32'({cur_line1, cur_col1}), 0);

    // Power-on init, TICK_DIV=4: first nibble on tick 41 after release.
    reset_n = 1'b1;
    last_rise = cyc;
    expect_nib("n3a", 0, 1'b0, 4'h3, 164, 4);
    expect_nib("n3b", 0, 1'b0, 4'h3, 28, 4);
    expect_nib("n3c", 0, 1'b0, 4'h3, 28, 4);
    expect_nib("n2", 0, 1'b0, 4'h2, 12, 4);
    expect_nib("func_hi", 0, 1'b0, 4'h2, 8, 4);
    expect_nib("func_lo", 0, 1'b0, 4'h8, 8, 4);
    expect_nib("disp_hi", 0, 1'b0, 4'h0, 8, 4);
    expect_nib("disp_lo", 0, 1'b0, 4'hC, 8, 4);
    expect_nib("clr_hi", 0, 1'b0, 4'h0, 8, 4);
    expect_nib("clr_lo", 0, 1'b0, 4'h1, 8, 4);
    expect_nib("entry_hi", 0, 1'b0, 4'h0, 16, 4);
    expect_nib("entry_lo", 0, 1'b0, 4'h6, 8, 4);
    check("init_ready", 32'(in_ready), 1);
    check("init_done", 32'(init_done), 1);
    check("init1_done", 32'(init_done1), 1);

    // Character 'A'.
    send(8'h41, 1'b1);
    check("a_busy", 32'(in_ready), 0);
    expect_nib("a_hi", 0, 1'b1, 4'h4, -1, 4);
    expect_nib("a_lo", 0, 1'b1, 4'h1, 8, 4);
    check("a_ready", 32'(in_ready), 1);
    check("a_col", 32'(cur_col), 1);
    check("a_line", 32'(cur_line), 0);

    // in_valid held with changing data: only the handshake byte 0x42 goes out, once.
    in_valid = 1'b1; in_data = 8'h42; in_rs = 1'b1;
    @(negedge clk);
    in_data = 8'h99; in_rs = 1'b0;
    check("hold_busy", 32'(in_ready), 0);
    expect_nib("hold_hi", 0, 1'b1, 4'h4, -1, 4);
    in_data = 8'h77;
    expect_nib("hold_lo", 0, 1'b1, 4'h2, 8, 4);
    check("hold_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (en === 1'b1) n++; end
    check("hold_once", n, 0);
    check("hold_col", 32'(cur_col), 2);

    // Set DDRAM 0xC5.
    send(8'hC5, 1'b0);
    expect_nib("ddr_hi", 0, 1'b0, 4'hC, -1, 4);
    expect_nib("ddr_lo", 0, 1'b0, 4'h5, 8, 4);
    check("ddr_line", 32'(cur_line), 1);
    check("ddr_col", 32'(cur_col), 5);

    // Clear: two extra wait ticks before in_ready.
    send(8'h01, 1'b0);
    expect_nib("cmd_clr_hi", 0, 1'b0, 4'h0, -1, 4);
    expect_nib("cmd_clr_lo", 0, 1'b0, 4'h1, 8, 4);
    check("cmd_clr_busy", 32'(in_ready), 0);
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("cmd_clr_wait", k, 8);
    check("cmd_clr_col", 32'(cur_col), 0);
    check("cmd_clr_line", 32'(cur_line), 0);

    // Fill line 0.
    for (int i = 0; i < 16; i++) begin
      ch = 8'h30 + 8'(i);
      xfer_char(ch);
    end
`ifdef LCD_AUTOWRAP_EN
    check("wrap1_busy", 32'(in_ready), 0);
    expect_nib("wrap1_hi", 0, 1'b0, 4'hC, 8, 4);
    expect_nib("wrap1_lo", 0, 1'b0, 4'h0, 8, 4);
    check("wrap1_ready", 32'(in_ready), 1);
    check("wrap1_col", 32'(cur_col), 0);
    check("wrap1_line", 32'(cur_line), 1);
    for (int i = 0; i < 16; i++) begin
      ch = 8'h50 + 8'(i);
      xfer_char(ch);
    end
    check("wrap2_busy", 32'(in_ready), 0);
    expect_nib("wrap2_hi", 0, 1'b0, 4'h8, 8, 4);
    expect_nib("wrap2_lo", 0, 1'b0, 4'h0, 8, 4);
    check("wrap2_col", 32'(cur_col), 0);
    check("wrap2_line", 32'(cur_line), 0);
`else
    check("nowrap_ready", 32'(in_ready), 1);
    check("nowrap_col", 32'(cur_col), 16);
    check("nowrap_line", 32'(cur_line), 0);
    for (int i = 0; i < 50; i++) begin
      ch = 8'h40 + 8'(i % 16);
      xfer_char(ch);
    end
    check("sat_col", 32'(cur_col), 63);
    check("sat_line", 32'(cur_line), 0);
`endif

    // Reset in the middle of a nibble.
    send(8'h41, 1'b1);
    k = 0;
    while (en !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
    check("mid_seen", 32'(k < 3000), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_en", 32'(en), 0);
    check("mid_ready", 32'(in_ready), 0);
    check("mid_init", 32'(init_done), 0);
    check("mid_col", 32'(cur_col), 0);
    reset_n = 1'b1;
    c0 = cyc;

    // LINES=1 instance (TICK_DIV=1, 2-tick delay) runs its whole init first.
    last_rise = c0;
    expect_nib("l1_n3a", 1, 1'b0, 4'h3, 3, 1);
    expect_nib("l1_n3b", 1, 1'b0, 4'h3, 7, 1);
    expect_nib("l1_n3c", 1, 1'b0, 4'h3, 7, 1);
    expect_nib("l1_n2", 1, 1'b0, 4'h2, 3, 1);
    expect_nib("l1_func_hi", 1, 1'b0, 4'h2, 2, 1);
    expect_nib("l1_func_lo", 1, 1'b0, 4'h0, 2, 1);
    expect_nib("l1_disp_hi", 1, 1'b0, 4'h0, 2, 1);
    expect_nib("l1_disp_lo", 1, 1'b0, 4'hC, 2, 1);
    expect_nib("l1_clr_hi", 1, 1'b0, 4'h0, 2, 1);
    expect_nib("l1_clr_lo", 1, 1'b0, 4'h1, 2, 1);
    expect_nib("l1_entry_hi", 1, 1'b0, 4'h0, 4, 1);
    expect_nib("l1_entry_lo", 1, 1'b0, 4'h6, 2, 1);
    check("l1_done", 32'(init_done1), 1);

    // Main instance restarts init from the full delay.
    check("re_init", 32'(init_done), 0);
    last_rise = c0;
    expect_nib("re_n3a", 0, 1'b0, 4'h3, 164, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
